dut_arbiter: RTL and testbench
==============================

DUT_ARBITER -- requirements
Module: dut_arbiter

Interface
REQ-001 Parameter: DW, 8, operand/result width.
REQ-002 Parameter: TIMEOUT, 255, max cycles from issue to dut_ready before abort (1..255).
REQ-003 Parameter: RR, 1, 1 = round-robin grant, 0 = fixed priority (requester 1 wins).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 req_start[1:0]  input  2  per-requester start pulse (0 = manual/switch path, 1 = BIST path).
REQ-007 req0_a, req0_b, req1_a, req1_b  input  DW each  requester operands, sampled on the req_start cycle.
REQ-008 req_done[1:0]  output  2  one-cycle completion pulse to the owning requester.
REQ-009 req_err[1:0]  output  2  one-cycle timeout pulse to the owning requester, coincident with req_done.
REQ-010 req_busy[1:0]  output  2  high while the requester has a pending or in-flight operation.
REQ-011 rsp_y  output  DW  result of the last completed operation, held until the next completion.
REQ-012 grant_id  output  1  owner of the in-flight operation, valid while dut_start or in WAIT.
REQ-013 dut_start  output  1  one-cycle start pulse to the shared dut.
REQ-014 dut_a, dut_b  output  DW each  operands to the dut, stable from dut_start until completion.
REQ-015 dut_y  input  DW  dut result.
REQ-016 dut_ready  input  1  dut status: drops the cycle after dut_start, rises when dut_y is valid.

Function
REQ-017 The block SHALL latch each req_start pulse and its operands into a per-requester pending slot, so single-cycle pulses are never lost.
REQ-018 A req_start on a requester whose req_busy is high SHALL be ignored (no overwrite, no queue).
REQ-019 FSM states: IDLE, ISSUE, ARM, WAIT, RESP.
REQ-020 IDLE: if any slot pending and dut_ready==1, pick the winner, load dut_a/dut_b and grant_id, go ISSUE; otherwise stay.
REQ-021 Grant with RR=1: if both are pending, grant the requester not served last (last-served resets to 1, so requester 0 wins first); a single pending requester always wins.
REQ-022 Grant with RR=0: requester 1 wins whenever both are pending.
REQ-023 ISSUE: assert dut_start for exactly one cycle, clear the timeout counter, go ARM.
REQ-024 ARM: wait for dut_ready==0, then go WAIT.
REQ-025 WAIT: on dut_ready==1, capture dut_y into rsp_y and go RESP.
REQ-026 Timeout: the counter increments every cycle in ARM and WAIT. When it reaches TIMEOUT, go RESP with the error flagged. rsp_y is left unchanged.
REQ-027 RESP: pulse req_done[grant_id] (and req_err[grant_id] on timeout), clear that pending slot, update last-served, go IDLE.
REQ-028 Issue latency: a req_start into an idle block with dut_ready=1 produces dut_start 2 cycles later (latch cycle, then IDLE decision).
REQ-029 Back-to-back: with both pending, the second dut_start follows the first req_done by at least 2 cycles. There is no idle gap beyond RESP and IDLE.
REQ-030 Simultaneous req_start[1:0]=2'b11 in one cycle: both slots latch, and the grant follows REQ-021/REQ-022.
REQ-031 A req_start from the served requester in the same cycle as its RESP SHALL be ignored, because busy is still high.
REQ-032 The dut operands and grant_id SHALL NOT change between ISSUE and RESP.

Reset
REQ-033 With rst==0 at a clock edge, the block SHALL go to IDLE, clear both pending slots, set last-served to 1 and zero the timeout counter.
REQ-034 During reset, all outputs SHALL be 0: dut_start, dut_a, dut_b, rsp_y, grant_id, req_done, req_err, req_busy.
REQ-035 Reset mid-operation SHALL abandon the in-flight operation with no req_done or req_err pulse.

Structure
REQ-036 Package dut_arb_pkg SHALL hold the FSM state encoding, the default DW and the default TIMEOUT.
REQ-037 One sub-module, rr_pick2, SHALL contain the combinational grant logic: pending[1:0], last and RR in; grant_valid and grant_id out.

Verification
REQ-038 Single request: req_start=2'b01 with a=8'h12, b=8'h34 and a model dut -> dut_start 2 cycles later, dut_a=8'h12, then req_done=2'b01 with rsp_y equal to the model result and req_err=0.
REQ-039 Contention with RR=1: req_start=2'b11 -> service order 0, 1. Repeat the 2'b11 pair -> order 0, 1 again. Each requester receives its own result.
REQ-040 Contention with RR=0: three consecutive 2'b11 rounds -> requester 1 is served first in every round.
REQ-041 Timeout with TIMEOUT=10: the dut never raises ready -> req_done and req_err pulse together 10 cycles after entering ARM, rsp_y is unchanged, and the next request is served normally.
REQ-042 Reset mid-WAIT: rst low for 1 cycle -> all outputs 0 and no done pulse. A new req_start=2'b10 afterwards completes normally.
REQ-043 Busy guard: a second req_start=2'b01 while req_busy[0]=1 with different operands -> ignored, with exactly one req_done carrying the original operands' result.

Source files
------------

// File: rtl/dut_arb_pkg.sv
// Shared definitions for the two-requester arbiter in front of a single shared dut.
// Holds the controller state encoding and the default operand width and timeout.
package dut_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/dut_arbiter_rr_pick2.sv
// Combinational two-way grant: round-robin against the last served requester,
// or fixed priority where requester 1 wins any tie.
module rr_pick2 (
  input  logic [1:0] pending,
  input  logic       last,
  input  logic       rr,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |pending;
    grant_id    = pending[1];
    if (&pending) begin
      grant_id = rr ? ~last : 1'b1;
    end
  end

endmodule

// File: rtl/dut_arbiter.sv
// Two-requester front end for one shared dut: latches start pulses into pending
// slots, issues one operation at a time, and aborts operations that exceed TIMEOUT.
module dut_arbiter
  import dut_arb_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int RR      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_start,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic [1:0]    req_done,
  output logic [1:0]    req_err,
  output logic [1:0]    req_busy,
  output logic [DW-1:0] rsp_y,
  output logic          grant_id,
  output logic          dut_start,
  output logic [DW-1:0] dut_a,
  output logic [DW-1:0] dut_b,
  input  logic [DW-1:0] dut_y,
  input  logic          dut_ready
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [1:0]    pend;
  logic [DW-1:0] slot_a [2];
  logic [DW-1:0] slot_b [2];
  logic          last;
  logic          err_flag;
  logic [7:0]    cnt;
  logic          timeout_hit;
  logic          pick_valid;
  logic          pick_id;

  rr_pick2 u_pick (
    .pending     (pend),
    .last        (last),
    .rr          (RR != 0),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  // Operand slots only load when their requester is not busy, so a busy
  // requester can never overwrite the operands of its queued operation.
  always_ff @(posedge clk) begin
    if (req_start[0] && !pend[0]) begin
      slot_a[0] <= req0_a;
      slot_b[0] <= req0_b;
    end
    if (req_start[1] && !pend[1]) begin
      slot_a[1] <= req1_a;
      slot_b[1] <= req1_b;
    end
  end

  always_comb begin
    timeout_hit = (cnt == CNT_LAST);
    state_nxt   = state;
    case (state)
      ST_IDLE:  if (pick_valid && dut_ready) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_ARM;
      ST_ARM: begin
        if (timeout_hit)     state_nxt = ST_RESP;
        else if (!dut_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (dut_ready || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pend     <= 2'b00;
      last     <= 1'b1;
      cnt      <= 8'd0;
      err_flag <= 1'b0;
      grant_id <= 1'b0;
      dut_a    <= '0;
      dut_b    <= '0;
      rsp_y    <= '0;
    end else begin
      state <= state_nxt;
      if (req_start[0] && !pend[0]) pend[0] <= 1'b1;
      if (req_start[1] && !pend[1]) pend[1] <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pick_valid && dut_ready) begin
            grant_id <= pick_id;
            dut_a    <= slot_a[pick_id];
            dut_b    <= slot_b[pick_id];
          end
        end
        ST_ISSUE: begin
          cnt      <= 8'd0;
          err_flag <= 1'b0;
        end
        ST_ARM: begin
          cnt <= cnt + 8'd1;
          if (timeout_hit) err_flag <= 1'b1;
        end
        // A ready dut wins over a coincident timeout: the result is valid.
        ST_WAIT: begin
          cnt <= cnt + 8'd1;
          if (dut_ready)        rsp_y    <= dut_y;
          else if (timeout_hit) err_flag <= 1'b1;
        end
        ST_RESP: begin
          pend[grant_id] <= 1'b0;
          last           <= grant_id;
        end
        default: ;
      endcase
    end
  end

  assign dut_start = (state == ST_ISSUE);
  assign req_busy  = pend;
  assign req_done  = (state == ST_RESP) ? (2'b01 << grant_id) : 2'b00;
  assign req_err   = (state == ST_RESP && err_flag) ? (2'b01 << grant_id) : 2'b00;

endmodule

// File: tb/tb_dut_arbiter.sv
// Bench for dut_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each talks to its own model dut, and a transaction-level scoreboard checks both.
module tb_dut_arbiter;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    st;
  logic [DW-1:0] a0, b0, a1, b1;
  logic          hang;

  logic [1:0]    dstart, gid, m_rdy;
  logic [1:0]    done_w [2];
  logic [1:0]    err_w  [2];
  logic [1:0]    busy_w [2];
  logic [DW-1:0] ry [2];
  logic [DW-1:0] da [2];
  logic [DW-1:0] db [2];
  logic [DW-1:0] m_y [2];
  int            m_cnt [2];

  int checks = 0;
  int errors = 0;

  dut_arbiter #(.DW(DW), .TIMEOUT(10), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .req_start(st),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .req_done(done_w[0]), .req_err(err_w[0]), .req_busy(busy_w[0]),
    .rsp_y(ry[0]), .grant_id(gid[0]), .dut_start(dstart[0]),
    .dut_a(da[0]), .dut_b(db[0]), .dut_y(m_y[0]), .dut_ready(m_rdy[0])
  );

  dut_arbiter #(.DW(DW), .TIMEOUT(10), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .req_start(st),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .req_done(done_w[1]), .req_err(err_w[1]), .req_busy(busy_w[1]),
    .rsp_y(ry[1]), .grant_id(gid[1]), .dut_start(dstart[1]),
    .dut_a(da[1]), .dut_b(db[1]), .dut_y(m_y[1]), .dut_ready(m_rdy[1])
  );

  // Model dut: ready drops after a start, returns a+b after a random delay,
  // and never completes while hang is set.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_rdy[k] <= 1'b1;
      end else if (dstart[k]) begin
        m_rdy[k] <= 1'b0;
        m_cnt[k] <= int'($urandom_range(0, 4));
        m_y[k]   <= da[k] + db[k];
      end else if (!m_rdy[k] && !hang) begin
        if (m_cnt[k] == 0) m_rdy[k] <= 1'b1;
        else               m_cnt[k] <= m_cnt[k] - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arbitration rule from the spec: ties go to the requester not served last
  // (round-robin) or to requester 1 (fixed); a lone requester always wins.
  function automatic logic win(input logic [1:0] p, input logic lst, input logic rr);
    if (p == 2'b11) return rr ? ~lst : 1'b1;
    return p[1];
  endfunction

  // Scoreboard state: pending slots with their operands, last served, last result.
  logic [1:0]      mp [2];
  logic [1:0]      pprev [2];
  logic            mlast [2];
  logic            infl [2];
  logic [DW-1:0]   ma [2][2];
  logic [DW-1:0]   mb [2][2];
  logic [DW-1:0]   mly [2];
  logic [DW+1:0]   qlog0 [$];
  logic [DW+1:0]   qlog1 [$];
  bit              rst_low_seen = 1'b0;
  bit              armed = 1'b0;
  logic [1:0]      t_oldp;
  logic            t_w;
  logic            t_done;
  logic [DW-1:0]   t_ey;

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      t_done = 1'b0;
      if (rst_low_seen) begin
        chk("rst_data", 32'({da[k], db[k], ry[k]}), 32'd0);
        chk("rst_ctrl", 32'({dstart[k], gid[k], done_w[k], err_w[k], busy_w[k]}), 32'd0);
      end else if (armed) begin
        chk("busy", 32'(busy_w[k]), 32'(mp[k]));
        if (dstart[k]) begin
          t_w = win(pprev[k], mlast[k], k == 0);
          chk("start_pending", 32'(pprev[k] != 2'b00), 32'd1);
          chk("grant", 32'(gid[k]), 32'(t_w));
          chk("dut_ops", 32'({da[k], db[k]}), 32'({ma[k][t_w], mb[k][t_w]}));
          infl[k] = t_w;
        end
        if (done_w[k] != 2'b00 || err_w[k] != 2'b00) begin
          t_ey = hang ? mly[k] : ma[k][infl[k]] + mb[k][infl[k]];
          chk("done", 32'(done_w[k]), 32'(2'b01 << infl[k]));
          chk("err", 32'(err_w[k]), hang ? 32'(2'b01 << infl[k]) : 32'd0);
          chk("rsp_y", 32'(ry[k]), 32'(t_ey));
          if (k == 0) qlog0.push_back({err_w[k][infl[k]], infl[k], ry[k]});
          else        qlog1.push_back({err_w[k][infl[k]], infl[k], ry[k]});
          mly[k]   = t_ey;
          mlast[k] = infl[k];
          t_done   = 1'b1;
        end
      end
      pprev[k] = mp[k];
      t_oldp   = mp[k];
      if (t_done) mp[k][infl[k]] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (st[i] && !t_oldp[i]) begin
          mp[k][i] = 1'b1;
          ma[k][i] = (i == 1) ? a1 : a0;
          mb[k][i] = (i == 1) ? b1 : b0;
        end
      end
    end
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mp[k] = 2'b00; mlast[k] = 1'b1; mly[k] = '0;
      end
      rst_low_seen = 1'b1;
      armed        = 1'b1;
    end else begin
      rst_low_seen = 1'b0;
    end
  end

  task automatic pulse(input logic [1:0] s, input logic [DW-1:0] x0, y0, x1, y1);
    @(posedge clk); #1;
    st = s; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    @(posedge clk); #1;
    st = 2'b00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy_w[0] == 2'b00 && busy_w[1] == 2'b00 && m_rdy == 2'b11) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", 32'(n < 300), 32'd1);
  endtask

  task automatic pop_log(input int k, output logic [DW+1:0] e);
    e = '1;
    if (k == 0 && qlog0.size() > 0) e = qlog0.pop_front();
    if (k == 1 && qlog1.size() > 0) e = qlog1.pop_front();
  endtask

  // Checks one completion per instance: requester id, error flag and result.
  task automatic expect_one(input string nm, input logic id, input logic er, input logic [DW-1:0] y);
    logic [DW+1:0] e;
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_count"}, 32'(k == 0 ? qlog0.size() : qlog1.size()), 32'd1);
      pop_log(k, e);
      chk({nm, "_entry"}, 32'(e), 32'({er, id, y}));
    end
  endtask

  typedef struct {
    logic [1:0]    st;
    logic [DW-1:0] a0, b0, a1, b1;
    logic          first_rr;
    logic          first_fp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW+1:0] e;
    logic [DW-1:0] ey;
    logic          id;
    int            n;

    tbl[0] = '{2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1};
    tbl[1] = '{2'b11, 8'h05, 8'h06, 8'h07, 8'h08, 1'b0, 1'b1};
    tbl[2] = '{2'b11, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 1'b1};
    tbl[3] = '{2'b10, 8'h00, 8'h00, 8'h21, 8'h0F, 1'b1, 1'b1};
    tbl[4] = '{2'b01, 8'h3C, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b1};
    tbl[6] = '{2'b11, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 1'b1};

    rst = 1'b0; st = 2'b00; hang = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Contention and single-request vectors; round-robin history carries over.
    for (int v = 0; v < 7; v++) begin
      qlog0.delete(); qlog1.delete();
      pulse(tbl[v].st, tbl[v].a0, tbl[v].b0, tbl[v].a1, tbl[v].b1);
      wait_idle();
      for (int k = 0; k < 2; k++) begin
        n = (tbl[v].st == 2'b11) ? 2 : 1;
        chk("tbl_count", 32'(k == 0 ? qlog0.size() : qlog1.size()), 32'(n));
        for (int j = 0; j < n; j++) begin
          id = (k == 0) ? tbl[v].first_rr : tbl[v].first_fp;
          if (j == 1) id = ~id;
          ey = id ? tbl[v].a1 + tbl[v].b1 : tbl[v].a0 + tbl[v].b0;
          pop_log(k, e);
          chk("tbl_order", 32'(e[DW]), 32'(id));
          chk("tbl_y", 32'(e[DW-1:0]), 32'(ey));
          chk("tbl_err", 32'(e[DW+1]), 32'd0);
        end
      end
    end

    // Single request: dut_start exactly two cycles after the start pulse.
    qlog0.delete(); qlog1.delete();
    @(posedge clk); #1;
    st = 2'b01; a0 = 8'h12; b0 = 8'h34;
    @(posedge clk); #1;
    st = 2'b00;
    chk("lat_early", 32'(dstart), 32'd0);
    @(posedge clk); #1;
    chk("lat_start", 32'(dstart), 32'h3);
    chk("lat_a_rr", 32'(da[0]), 32'h12);
    chk("lat_a_fp", 32'(da[1]), 32'h12);
    wait_idle();
    expect_one("single", 1'b0, 1'b0, 8'h46);

    // Timeout: the dut never completes, abort lands 10 cycles after ARM.
    hang = 1'b1;
    qlog0.delete(); qlog1.delete();
    pulse(2'b01, 8'h77, 8'h01, 8'h00, 8'h00);
    n = 0;
    while (!dstart[0] && n < 20) begin @(posedge clk); #1; n++; end
    chk("to_start_seen", 32'(n < 20), 32'd1);
    n = 0;
    while (done_w[0] == 2'b00 && n < 40) begin @(posedge clk); #1; n++; end
    chk("to_latency", 32'(n), 32'd11);
    chk("to_err_rr", 32'(err_w[0]), 32'h1);
    chk("to_err_fp", 32'(err_w[1]), 32'h1);
    @(posedge clk); #1;
    hang = 1'b0;
    wait_idle();
    expect_one("timeout", 1'b0, 1'b1, 8'h46);
    pulse(2'b01, 8'h40, 8'h02, 8'h00, 8'h00);
    wait_idle();
    expect_one("after_to", 1'b0, 1'b0, 8'h42);

    // Reset while the dut is still busy: no completion, then normal service.
    hang = 1'b1;
    qlog0.delete(); qlog1.delete();
    pulse(2'b01, 8'h55, 8'h11, 8'h00, 8'h00);
    n = 0;
    while (!dstart[0] && n < 20) begin @(posedge clk); #1; n++; end
    chk("rw_start_seen", 32'(n < 20), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    hang = 1'b0;
    chk("rw_zero_ctrl", 32'({dstart, done_w[0], done_w[1], busy_w[0], busy_w[1]}), 32'd0);
    wait_idle();
    chk("rw_no_done", 32'(qlog0.size() + qlog1.size()), 32'd0);
    pulse(2'b10, 8'h00, 8'h00, 8'h21, 8'h0F);
    wait_idle();
    expect_one("after_rst", 1'b1, 1'b0, 8'h30);

    // Busy guard: a second start while busy is dropped with its operands.
    qlog0.delete(); qlog1.delete();
    @(posedge clk); #1;
    st = 2'b01; a0 = 8'h05; b0 = 8'h06;
    @(posedge clk); #1;
    chk("guard_busy", 32'(busy_w[0][0]), 32'd1);
    st = 2'b01; a0 = 8'h50; b0 = 8'h60;
    @(posedge clk); #1;
    st = 2'b00;
    wait_idle();
    expect_one("guard", 1'b0, 1'b0, 8'h0B);

    // Random traffic against the scoreboard.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      st = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
    end
    @(posedge clk); #1;
    st = 2'b00;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
